// File: rtl/ph_path_tracer.sv
// ph_path_tracer: greedy pheromone-following walker on a MAP_LEN x MAP_LEN grid.
// From (0,0) it probes each legal neighbour (never reversing, never leaving the
// map), picks the free neighbour with the highest pheromone (ties keep the lower
// direction code), offers that step on a valid/ready port and repeats until it
// reaches the goal, hits a dead end, or uses up MAX_STEPS.
module ph_path_tracer #(
  parameter int POS_ADDR     = 4,
  parameter int PH_DATA_SIZE = 16,
  parameter int MAP_LEN      = 10,
  parameter int MAX_STEPS    = 200,
  parameter int GOAL_X       = 9,
  parameter int GOAL_Y       = 9
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  output logic                    busy,
  output logic [2*POS_ADDR-1:0]   rd_addr,
  output logic                    rd_en,
  input  logic [PH_DATA_SIZE-1:0] ph_rdata,
  input  logic                    map_rdata,
  output logic                    step_valid,
  input  logic                    step_ready,
  output logic [1:0]              step,
  output logic                    done,
  output logic                    fail
);

  localparam int ADDR_W = 2 * POS_ADDR;
  localparam int CNT_W  = $clog2(MAX_STEPS + 1);

  localparam logic [POS_ADDR-1:0] MAX_COORD = POS_ADDR'(MAP_LEN - 1);
  localparam logic [POS_ADDR-1:0] GOAL_X_C  = POS_ADDR'(GOAL_X);
  localparam logic [POS_ADDR-1:0] GOAL_Y_C  = POS_ADDR'(GOAL_Y);
  localparam logic [ADDR_W-1:0]   MAP_LEN_W = ADDR_W'(MAP_LEN);
  localparam logic [CNT_W-1:0]    MAX_CNT   = CNT_W'(MAX_STEPS);

  typedef enum logic [2:0] {
    IDLE,
    PROBE,
    CAPTURE,
    DECIDE,
    EMIT,
    END
  } state_t;

  state_t state;
  state_t state_next;

  // Walker state
  logic [POS_ADDR-1:0]     pos_x;
  logic [POS_ADDR-1:0]     pos_y;
  logic [1:0]              prev_dir;
  logic                    prev_valid;
  logic [CNT_W-1:0]        count;

  // Scan state: candidate currently being probed and best so far
  logic [1:0]              cand_dir;
  logic [1:0]              best_dir;
  logic [PH_DATA_SIZE-1:0] best_ph;
  logic                    best_found;

  // Shared candidate search inputs and results
  logic [POS_ADDR-1:0]     srch_x;
  logic [POS_ADDR-1:0]     srch_y;
  logic                    srch_pv;
  logic [1:0]              srch_pd;
  logic [2:0]              srch_from;
  logic [2:0]              srch;
  logic                    srch_found;
  logic [1:0]              srch_dir;
  logic [POS_ADDR-1:0]     cand_x;
  logic [POS_ADDR-1:0]     cand_y;
  logic [ADDR_W-1:0]       srch_addr;

  // Position after the step being offered, and end-of-walk tests on it
  logic [POS_ADDR-1:0]     new_x;
  logic [POS_ADDR-1:0]     new_y;
  logic [CNT_W-1:0]        count_inc;
  logic                    at_goal;
  logic                    at_limit;
  logic                    eligible;

  // Lowest legal direction code at or above 'from': inside the map on both
  // axes and not the reverse of the previous step. Bit 2 flags a hit.
  function automatic logic [2:0] find_cand(
    input logic [POS_ADDR-1:0] fx,
    input logic [POS_ADDR-1:0] fy,
    input logic                pv,
    input logic [1:0]          pd,
    input logic [2:0]          from
  );
    logic [3:0] ok;
    logic [2:0] res;
    ok[0] = (fy != '0);
    ok[1] = (fx != MAX_COORD);
    ok[2] = (fy != MAX_COORD);
    ok[3] = (fx != '0);
    if (pv) begin
      ok[pd ^ 2'b10] = 1'b0;
    end
    res = '0;
    for (int i = 3; i >= 0; i--) begin
      if ((3'(i) >= from) && ok[2'(i)]) begin
        res = {1'b1, 2'(i)};
      end
    end
    return res;
  endfunction

  // Coordinates one step away in direction dir, packed as {x, y}.
  function automatic logic [ADDR_W-1:0] move(
    input logic [POS_ADDR-1:0] fx,
    input logic [POS_ADDR-1:0] fy,
    input logic [1:0]          dir
  );
    logic [POS_ADDR-1:0] nx;
    logic [POS_ADDR-1:0] ny;
    nx = fx;
    ny = fy;
    case (dir)
      2'b00:   ny = fy - 1'b1;
      2'b01:   nx = fx + 1'b1;
      2'b10:   ny = fy + 1'b1;
      default: nx = fx - 1'b1;
    endcase
    return {nx, ny};
  endfunction

  // Linear memory address y*MAP_LEN + x.
  function automatic logic [ADDR_W-1:0] cell_addr(
    input logic [POS_ADDR-1:0] fx,
    input logic [POS_ADDR-1:0] fy
  );
    return ({{POS_ADDR{1'b0}}, fy} * MAP_LEN_W) + {{POS_ADDR{1'b0}}, fx};
  endfunction

  // Pick which position/scan point the single search unit looks at: the
  // origin when starting, the next direction while scanning, the new cell
  // when a step is being accepted.
  always_comb begin
    srch_x    = '0;
    srch_y    = '0;
    srch_pv   = 1'b0;
    srch_pd   = 2'b00;
    srch_from = 3'd0;
    case (state)
      CAPTURE: begin
        srch_x    = pos_x;
        srch_y    = pos_y;
        srch_pv   = prev_valid;
        srch_pd   = prev_dir;
        srch_from = {1'b0, cand_dir} + 3'd1;
      end
      EMIT: begin
        srch_x  = new_x;
        srch_y  = new_y;
        srch_pv = 1'b1;
        srch_pd = step;
      end
      default: begin
      end
    endcase
  end

  assign srch             = find_cand(srch_x, srch_y, srch_pv, srch_pd, srch_from);
  assign srch_found       = srch[2];
  assign srch_dir         = srch[1:0];
  assign {cand_x, cand_y} = move(srch_x, srch_y, srch_dir);
  assign srch_addr        = cell_addr(cand_x, cand_y);

  assign {new_x, new_y}   = move(pos_x, pos_y, step);
  assign count_inc        = count + 1'b1;
  assign at_goal          = (new_x == GOAL_X_C) && (new_y == GOAL_Y_C);
  assign at_limit         = (count_inc == MAX_CNT);
  assign eligible         = map_rdata && (!best_found || (ph_rdata > best_ph));

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic and state-decoded strobes
  always_comb begin
    state_next = state;
    busy       = 1'b0;
    rd_en      = 1'b0;
    step_valid = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_next = PROBE;
        end
      end
      PROBE: begin
        busy       = 1'b1;
        rd_en      = 1'b1;
        state_next = CAPTURE;
      end
      CAPTURE: begin
        busy       = 1'b1;
        state_next = srch_found ? PROBE : DECIDE;
      end
      DECIDE: begin
        busy       = 1'b1;
        state_next = best_found ? EMIT : END;
      end
      EMIT: begin
        busy       = 1'b1;
        step_valid = 1'b1;
        if (step_ready) begin
          if (at_goal || at_limit) begin
            state_next = END;
          end else if (srch_found) begin
            state_next = PROBE;
          end else begin
            state_next = DECIDE;
          end
        end
      end
      END: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Walker datapath: position, scan bookkeeping, read address and results
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pos_x      <= '0;
      pos_y      <= '0;
      prev_dir   <= 2'b00;
      prev_valid <= 1'b0;
      count      <= '0;
      cand_dir   <= 2'b00;
      best_dir   <= 2'b00;
      best_ph    <= '0;
      best_found <= 1'b0;
      rd_addr    <= '0;
      step       <= 2'b00;
      done       <= 1'b0;
      fail       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            pos_x      <= '0;
            pos_y      <= '0;
            prev_valid <= 1'b0;
            count      <= '0;
            best_found <= 1'b0;
            best_ph    <= '0;
            done       <= 1'b0;
            fail       <= 1'b0;
            cand_dir   <= srch_dir;
            rd_addr    <= srch_addr;
          end
        end
        CAPTURE: begin
          if (eligible) begin
            best_found <= 1'b1;
            best_ph    <= ph_rdata;
            best_dir   <= cand_dir;
          end
          if (srch_found) begin
            cand_dir <= srch_dir;
            rd_addr  <= srch_addr;
          end
        end
        DECIDE: begin
          if (best_found) begin
            step <= best_dir;
          end else begin
            fail <= 1'b1;
          end
        end
        EMIT: begin
          if (step_ready) begin
            pos_x      <= new_x;
            pos_y      <= new_y;
            prev_dir   <= step;
            prev_valid <= 1'b1;
            count      <= count_inc;
            best_found <= 1'b0;
            best_ph    <= '0;
            if (at_goal) begin
              done <= 1'b1;
            end else if (at_limit) begin
              fail <= 1'b1;
            end else if (srch_found) begin
              cand_dir <= srch_dir;
              rd_addr  <= srch_addr;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ph_path_tracer.sv
// Testbench for ph_path_tracer: two instances (default limits and MAX_STEPS=6)
// share a behavioural pheromone/obstacle memory with one-cycle read latency.
// Stimulus pushes expected step codes into a queue; a monitor pops and compares
// on every accepted step.
module tb_ph_path_tracer;

  localparam int POS_ADDR     = 4;
  localparam int PH_DATA_SIZE = 16;

  logic clk        = 1'b0;
  logic rst        = 1'b1;
  logic start_a    = 1'b0;
  logic start_b    = 1'b0;
  logic step_ready = 1'b1;

  logic                    a_busy, a_rd_en, a_step_valid, a_done, a_fail, a_map;
  logic [2*POS_ADDR-1:0]   a_rd_addr;
  logic [1:0]              a_step;
  logic [PH_DATA_SIZE-1:0] a_ph;

  logic                    b_busy, b_rd_en, b_step_valid, b_done, b_fail, b_map;
  logic [2*POS_ADDR-1:0]   b_rd_addr;
  logic [1:0]              b_step;
  logic [PH_DATA_SIZE-1:0] b_ph;

  logic [PH_DATA_SIZE-1:0] ph_mem  [0:255];
  logic                    map_mem [0:255];

  int n_compared = 0;
  int n_mismatch = 0;
  int steps_seen = 0;
  logic [1:0] exp_q [$];

  always #5 clk = ~clk;

  ph_path_tracer dut_a (
    .clk        (clk),
    .rst        (rst),
    .start      (start_a),
    .busy       (a_busy),
    .rd_addr    (a_rd_addr),
    .rd_en      (a_rd_en),
    .ph_rdata   (a_ph),
    .map_rdata  (a_map),
    .step_valid (a_step_valid),
    .step_ready (step_ready),
    .step       (a_step),
    .done       (a_done),
    .fail       (a_fail)
  );

  ph_path_tracer #(.MAX_STEPS(6)) dut_b (
    .clk        (clk),
    .rst        (rst),
    .start      (start_b),
    .busy       (b_busy),
    .rd_addr    (b_rd_addr),
    .rd_en      (b_rd_en),
    .ph_rdata   (b_ph),
    .map_rdata  (b_map),
    .step_valid (b_step_valid),
    .step_ready (step_ready),
    .step       (b_step),
    .done       (b_done),
    .fail       (b_fail)
  );

  // Synchronous memories, one read port per instance
  always @(posedge clk) begin
    if (a_rd_en) begin
      a_ph  <= ph_mem[a_rd_addr];
      a_map <= map_mem[a_rd_addr];
    end
    if (b_rd_en) begin
      b_ph  <= ph_mem[b_rd_addr];
      b_map <= map_mem[b_rd_addr];
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] required);
    n_compared++;
    if (actual !== required) begin
      n_mismatch++;
      $display("[TB] FAIL %s: actual=%0d required=%0d", name, actual, required);
    end
  endtask

  task automatic checkStep(input logic [1:0] actual);
    logic [1:0] required;
    steps_seen++;
    if (exp_q.size() == 0) begin
      n_compared++;
      n_mismatch++;
      $display("[TB] FAIL unexpected_step: actual=%0d required=none", actual);
    end else begin
      required = exp_q.pop_front();
      checkOutput("step", 32'(actual), 32'(required));
    end
  endtask

  // Monitor: a step is accepted at the next rising edge when valid and ready
  initial begin
    forever begin
      @(negedge clk);
      if (!rst && step_ready) begin
        if (a_step_valid) checkStep(a_step);
        if (b_step_valid) checkStep(b_step);
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clearMap();
    for (int i = 0; i < 256; i++) begin
      ph_mem[i]  = '0;
      map_mem[i] = 1'b1;
    end
  endtask

  task automatic applyStimulus(input bit use_b);
    if (use_b) start_b = 1'b1;
    else       start_a = 1'b1;
    tick();
    start_a = 1'b0;
    start_b = 1'b0;
  endtask

  task automatic waitValid(input bit use_b, input int limit, output int cycles);
    cycles = limit + 1;
    for (int i = 1; i <= limit; i++) begin
      @(negedge clk);
      if (use_b ? b_step_valid : a_step_valid) begin
        cycles = i;
        break;
      end
    end
  endtask

  task automatic waitEnd(input bit use_b, input int limit, output int cycles);
    cycles = limit + 1;
    for (int i = 1; i <= limit; i++) begin
      @(negedge clk);
      if (use_b ? (b_done || b_fail) : (a_done || a_fail)) begin
        cycles = i;
        break;
      end
    end
  endtask

  task automatic checkResetOutputs(input bit use_b, input string tag);
    if (use_b) begin
      checkOutput({tag, "_flags"}, 32'({b_busy, b_rd_en, b_step_valid, b_done, b_fail}), 32'd0);
      checkOutput({tag, "_addr_step"}, 32'({b_rd_addr, b_step}), 32'd0);
    end else begin
      checkOutput({tag, "_flags"}, 32'({a_busy, a_rd_en, a_step_valid, a_done, a_fail}), 32'd0);
      checkOutput({tag, "_addr_step"}, 32'({a_rd_addr, a_step}), 32'd0);
    end
  endtask

  task automatic pulseReset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_q.delete();
  endtask

  initial begin
    int cyc;
    int bad;
    int bad_s;
    int bad_r;

    clearMap();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checkResetOutputs(0, "reset_a");
    checkResetOutputs(1, "reset_b");
    rst = 1'b0;
    tick();

    // Right neighbour has the stronger trail: first step right within 8 cycles
    $display("[TB] first step latency");
    clearMap();
    ph_mem[1]  = 16'd5;
    ph_mem[10] = 16'd3;
    exp_q.push_back(2'b01);
    steps_seen = 0;
    applyStimulus(0);
    waitValid(0, 8, cyc);
    checkOutput("first_step_within_8", 32'(cyc <= 8), 32'd1);
    tick();
    rst = 1'b1;
    #1;
    checkResetOutputs(0, "reset_mid_trace_a");
    tick();
    rst = 1'b0;
    bad = 0;
    repeat (10) begin
      @(negedge clk);
      if (a_step_valid) bad++;
    end
    checkOutput("no_step_after_reset", bad, 0);
    checkOutput("steps_before_reset", steps_seen, 1);

    // Staircase of ph=10 to the goal: 18 alternating steps then done
    $display("[TB] staircase walk");
    clearMap();
    for (int k = 1; k <= 9; k++) begin
      ph_mem[(k - 1) * 10 + k] = 16'd10;
      ph_mem[k * 10 + k]       = 16'd10;
      exp_q.push_back(2'b01);
      exp_q.push_back(2'b10);
    end
    steps_seen = 0;
    applyStimulus(0);
    waitEnd(0, 400, cyc);
    checkOutput("stair_finished", 32'(cyc <= 400), 32'd1);
    checkOutput("stair_steps", steps_seen, 18);
    checkOutput("stair_done", 32'(a_done), 32'd1);
    checkOutput("stair_fail", 32'(a_fail), 32'd0);
    checkOutput("stair_busy_end", 32'(a_busy), 32'd0);
    tick();
    checkOutput("stair_done_held", 32'(a_done), 32'd1);
    checkOutput("stair_busy_idle", 32'(a_busy), 32'd0);

    // Equal trails right and down: the lower code (right) wins
    $display("[TB] tie break");
    clearMap();
    ph_mem[1]  = 16'd7;
    ph_mem[10] = 16'd7;
    exp_q.push_back(2'b01);
    steps_seen = 0;
    applyStimulus(0);
    checkOutput("done_cleared_on_start", 32'(a_done), 32'd0);
    waitValid(0, 8, cyc);
    checkOutput("tie_step_within_8", 32'(cyc <= 8), 32'd1);
    tick();
    checkOutput("tie_steps", steps_seen, 1);
    pulseReset();

    // Both in-map neighbours of the origin blocked: fail, no step
    $display("[TB] dead end");
    clearMap();
    map_mem[1]  = 1'b0;
    map_mem[10] = 1'b0;
    steps_seen = 0;
    applyStimulus(0);
    waitEnd(0, 6, cyc);
    checkOutput("dead_end_within_6", 32'(cyc <= 6), 32'd1);
    checkOutput("dead_end_fail", 32'(a_fail), 32'd1);
    checkOutput("dead_end_done", 32'(a_done), 32'd0);
    checkOutput("dead_end_steps", steps_seen, 0);
    tick();

    // Consumer stalls: step held stable and no new reads until accepted
    $display("[TB] backpressure");
    clearMap();
    ph_mem[1] = 16'd5;
    step_ready = 1'b0;
    exp_q.push_back(2'b01);
    steps_seen = 0;
    applyStimulus(0);
    waitValid(0, 8, cyc);
    checkOutput("stall_step_within_8", 32'(cyc <= 8), 32'd1);
    bad = 0;
    bad_s = 0;
    bad_r = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (a_step_valid !== 1'b1) bad++;
      if (a_step !== 2'b01) bad_s++;
      if (a_rd_en !== 1'b0) bad_r++;
    end
    checkOutput("stall_valid_held", bad, 0);
    checkOutput("stall_step_stable", bad_s, 0);
    checkOutput("stall_no_read", bad_r, 0);
    checkOutput("stall_no_accept", steps_seen, 0);
    @(posedge clk);
    #1;
    step_ready = 1'b1;
    @(negedge clk);
    tick();
    checkOutput("stall_one_accept", steps_seen, 1);
    pulseReset();

    // Square trail loop with a six-step limit: six steps then fail
    $display("[TB] step limit");
    clearMap();
    ph_mem[0]  = 16'd9;
    ph_mem[1]  = 16'd9;
    ph_mem[11] = 16'd9;
    ph_mem[10] = 16'd9;
    exp_q.push_back(2'b01);
    exp_q.push_back(2'b10);
    exp_q.push_back(2'b11);
    exp_q.push_back(2'b00);
    exp_q.push_back(2'b01);
    exp_q.push_back(2'b10);
    steps_seen = 0;
    applyStimulus(1);
    waitEnd(1, 200, cyc);
    checkOutput("limit_finished", 32'(cyc <= 200), 32'd1);
    checkOutput("limit_steps", steps_seen, 6);
    checkOutput("limit_fail", 32'(b_fail), 32'd1);
    checkOutput("limit_done", 32'(b_done), 32'd0);
    tick();

    // Reset while a step is on offer clears every output immediately
    $display("[TB] reset during emit");
    step_ready = 1'b0;
    steps_seen = 0;
    applyStimulus(1);
    waitValid(1, 8, cyc);
    checkOutput("emit_reached", 32'(cyc <= 8), 32'd1);
    checkOutput("emit_step_before_reset", 32'(b_step), 32'd1);
    #1;
    rst = 1'b1;
    #1;
    checkResetOutputs(1, "reset_in_emit_b");
    tick();
    rst = 1'b0;
    step_ready = 1'b1;
    bad = 0;
    repeat (10) begin
      @(negedge clk);
      if (b_step_valid) bad++;
    end
    checkOutput("no_step_after_emit_reset", bad, 0);
    checkOutput("emit_reset_steps", steps_seen, 0);

    checkOutput("queue_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatch);
    $finish;
  end

endmodule
